wave_gen_param: RTL and testbench

//  Parametrised successor to the FIFO-feeding function generator. Phase-accumulator DDS producing

---
 rtl/wave_gen_param.sv | 181 ++++++++++++++++++
 tb/tb_wave_gen_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wave_gen_param.sv
// wave_gen_param -- phase-accumulator DDS function generator feeding a FIFO.
//
// It produces sine, cosine, triangle or square samples, scales them by an
// unsigned amplitude with saturation, and writes them into a downstream FIFO.
// A nonzero burst length stops generation after that many samples. FIFO-full
// backpressure freezes the whole pipeline. The sine table is an external
// registered ROM: the address is issued in one cycle and the data returns in
// the next.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   en_i          run enable; low returns the block to IDLE
//   cfg_i         configuration strobe (amp/step/sel/len latched in CONFIG)
//   amp_i         amplitude, unity = 2**(AMP_WIDTH-1)
//   step_i        phase increment per sample
//   sel_i         00 sine, 01 cosine, 10 triangle, 11 square
//   len_i         burst length in samples, 0 = continuous
//   fifo_full_i   downstream FIFO full (stalls everything)
//   lut_en_o      ROM read enable (ROM holds its output when low)
//   lut_addr_o    ROM address
//   lut_data_i    ROM data, one cycle after the address
//   wr_en_o       FIFO write strobe
//   data_o        sample to FIFO
//   busy_o        high in CONFIG or GEN
//   done_o        one-cycle pulse with the last write of a burst
module wave_gen_param #(
  parameter int DATA_WIDTH  = 16,
  parameter int AMP_WIDTH   = 8,
  parameter int LUT_ADDR    = 8,
  parameter int PHASE_WIDTH = 16,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_i,
  input  logic                         cfg_i,
  input  logic [AMP_WIDTH-1:0]         amp_i,
  input  logic [PHASE_WIDTH-1:0]       step_i,
  input  logic [1:0]                   sel_i,
  input  logic [LEN_WIDTH-1:0]         len_i,
  input  logic                         fifo_full_i,
  output logic                         lut_en_o,
  output logic [LUT_ADDR-1:0]          lut_addr_o,
  input  logic signed [DATA_WIDTH-1:0] lut_data_i,
  output logic                         wr_en_o,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         busy_o,
  output logic                         done_o
);

  // One register stage between issue and the output register:
  // vld_pipe[0] qualifies a_r / lut_data_i, vld_pipe[1] qualifies data_o.
  localparam int STAGES = 1;
  // Stage-1 samples are carried two bits wider so the triangle math never
  // wraps; the product adds the amplitude width plus its zero sign bit.
  localparam int SW = DATA_WIDTH + 2;
  localparam int PW = SW + AMP_WIDTH + 1;

  localparam logic signed [SW-1:0] MAX_S = {3'b000, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] P_MAX = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] P_MIN = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [LUT_ADDR-1:0]  QTR   = {2'b01, {(LUT_ADDR-2){1'b0}}};

  typedef enum logic [1:0] {IDLE, CONFIG, GEN} state_t;

  state_t                   state;
  logic [AMP_WIDTH-1:0]     amp_r;
  logic [PHASE_WIDTH-1:0]   step_r;
  logic [1:0]               sel_r;
  logic [LEN_WIDTH-1:0]     len_r;
  logic [PHASE_WIDTH-1:0]   phase;
  logic [LEN_WIDTH-1:0]     count;
  logic [LUT_ADDR-1:0]      a_r;
  logic [STAGES:0]          vld_pipe;

  logic                     adv, stay, exhausted, issue, last_wr;
  logic [LUT_ADDR-1:0]      a;
  logic signed [SW-1:0]     two_u, tri_v, s;
  logic signed [PW-1:0]     p, r;
  logic signed [DATA_WIDTH-1:0] sat;

  // ---------------- issue / control ----------------
  assign adv       = !fifo_full_i;
  // Staying in GEN this cycle; any exit flushes, so nothing new is issued.
  assign stay      = (state == GEN) && en_i && !cfg_i;
  assign exhausted = (len_r != '0) && (count == len_r);
  assign issue     = stay && adv && !exhausted;
  assign a         = phase[PHASE_WIDTH-1 -: LUT_ADDR];

  assign lut_en_o   = issue;
  assign lut_addr_o = !issue ? '0 : (sel_r == 2'b01) ? a + QTR : a;

  assign wr_en_o = vld_pipe[STAGES] && adv;
  // Final write of a burst: everything issued and nothing left behind it.
  assign last_wr = wr_en_o && exhausted && !vld_pipe[0];
  assign done_o  = stay && last_wr;
  assign busy_o  = (state != IDLE);

  // ---------------- stage 1: waveform select ----------------
  // Triangle: 2u = a[LUT_ADDR-2:0] << (DATA_WIDTH-LUT_ADDR+1).
  assign two_u = {2'b00, a_r[LUT_ADDR-2:0], {(DATA_WIDTH-LUT_ADDR+1){1'b0}}};
  assign tri_v = a_r[LUT_ADDR-1] ? (MAX_S - two_u) : (two_u - MAX_S);

  always_comb begin
    s = {{2{lut_data_i[DATA_WIDTH-1]}}, lut_data_i};
    case (sel_r)
      2'b10:   s = tri_v;
      2'b11:   s = a_r[LUT_ADDR-1] ? -MAX_S : MAX_S;
      default: s = {{2{lut_data_i[DATA_WIDTH-1]}}, lut_data_i};
    endcase
  end

  // ---------------- stage 2: scale + saturate ----------------
  assign p = $signed({{(AMP_WIDTH+1){s[SW-1]}}, s}) *
             $signed({{SW{1'b0}}, 1'b0, amp_r});
  assign r = p >>> (AMP_WIDTH-1);  // arithmetic shift = floor

  always_comb begin
    sat = r[DATA_WIDTH-1:0];
    if (r > P_MAX)      sat = P_MAX[DATA_WIDTH-1:0];
    else if (r < P_MIN) sat = P_MIN[DATA_WIDTH-1:0];
  end

  // ---------------- FSM + datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      amp_r    <= '0;
      step_r   <= '0;
      sel_r    <= '0;
      len_r    <= '0;
      phase    <= '0;
      count    <= '0;
      a_r      <= '0;
      vld_pipe <= '0;
      data_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          vld_pipe <= '0;
          if (cfg_i) state <= CONFIG;
        end
        CONFIG: begin
          amp_r    <= amp_i;
          step_r   <= step_i;
          sel_r    <= sel_i;
          len_r    <= len_i;
          phase    <= '0;
          count    <= '0;
          vld_pipe <= '0;
          state    <= en_i ? GEN : IDLE;
        end
        GEN: begin
          if (!en_i) begin
            state    <= IDLE;
            vld_pipe <= '0;
          end else if (cfg_i) begin
            state    <= CONFIG;
            vld_pipe <= '0;
          end else if (last_wr) begin
            state    <= IDLE;
            vld_pipe <= '0;
          end else if (adv) begin
            if (issue) begin
              phase <= phase + step_r;
              count <= count + LEN_WIDTH'(1);
              a_r   <= a;
            end
            vld_pipe <= {vld_pipe[STAGES-1:0], issue};
            if (vld_pipe[0]) data_o <= sat;
          end
        end
        default: begin
          state    <= IDLE;
          vld_pipe <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_gen_param.sv
// Directed bench for wave_gen_param: square/triangle/amplitude vectors,
// sine/cosine against a model ROM, backpressure, burst end, reconfigure and
// reset during generation.
module tb_wave_gen_param;

  logic               clk = 1'b0;
  logic               rst;
  logic               en_i, cfg_i, fifo_full_i;
  logic [7:0]         amp_i;
  logic [15:0]        step_i;
  logic [1:0]         sel_i;
  logic [15:0]        len_i;
  logic               lut_en_o;
  logic [7:0]         lut_addr_o;
  logic signed [15:0] lut_data_i;
  logic               wr_en_o;
  logic signed [15:0] data_o;
  logic               busy_o, done_o;

  int checks = 0;
  int errors = 0;
  int wq[$];
  int first_idx;
  int done_cnt;
  int done_idx;

  always #5 clk = ~clk;

  wave_gen_param dut (
    .clk(clk), .rst(rst), .en_i(en_i), .cfg_i(cfg_i), .amp_i(amp_i),
    .step_i(step_i), .sel_i(sel_i), .len_i(len_i), .fifo_full_i(fifo_full_i),
    .lut_en_o(lut_en_o), .lut_addr_o(lut_addr_o), .lut_data_i(lut_data_i),
    .wr_en_o(wr_en_o), .data_o(data_o), .busy_o(busy_o), .done_o(done_o)
  );

  // Model ROM: any distinct, easily hand-computed contents will do.
  function automatic int rom_val(input int i);
    return i * 251 - 32000;
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) lut_data_i <= '0;
    else if (lut_en_o) lut_data_i <= 16'(rom_val(int'(lut_addr_o)));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int q_at(input int i);
    return (wq.size() > i) ? wq[i] : 99999;
  endfunction

  task automatic clr();
    wq.delete();
    first_idx = -1;
    done_cnt  = 0;
    done_idx  = -1;
  endtask

  // Samples n cycles at the falling edge, logging accepted writes.
  task automatic collect(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (wr_en_o) begin
        if (first_idx < 0) first_idx = i;
        wq.push_back(int'(data_o));
      end
      if (done_o) begin
        done_cnt++;
        done_idx = wr_en_o ? wq.size() : -1;
      end
    end
  endtask

  // Returns in the first GEN cycle (before its falling edge).
  task automatic cfg(input logic [1:0] sel, input logic [15:0] step,
                     input logic [7:0] amp, input logic [15:0] len);
    @(posedge clk); #1;
    sel_i = sel; step_i = step; amp_i = amp; len_i = len;
    cfg_i = 1'b1; en_i = 1'b1;
    @(posedge clk); #1;
    cfg_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic stop();
    @(posedge clk); #1;
    en_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int exp_sq[6];
    exp_sq = '{32767, 32767, -32767, -32767, 32767, 32767};
    rst = 1'b1; en_i = 1'b0; cfg_i = 1'b0; fifo_full_i = 1'b0;
    amp_i = '0; step_i = '0; sel_i = '0; len_i = '0;

    repeat (2) @(negedge clk);
    chk("rst_wr_en", wr_en_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_lut_en", lut_en_o, 0);
    chk("rst_lut_addr", lut_addr_o, 0);
    chk("rst_done", done_o, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Square, unity gain, quarter-cycle step.
    cfg(2'b11, 16'h4000, 8'd128, 16'd0);
    clr(); collect(8);
    chk("sq_first_wr_cycle", first_idx, 2);
    chk("sq_count", wq.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("sq[%0d]", i), q_at(i), exp_sq[i]);
    stop();

    // Square, amp 255: both rails saturate.
    cfg(2'b11, 16'h4000, 8'd255, 16'd0);
    clr(); collect(5);
    chk("sat_pos", q_at(0), 32767);
    chk("sat_neg", q_at(2), -32768);
    stop();

    // Square, amp 64: floor rounding.
    cfg(2'b11, 16'h4000, 8'd64, 16'd0);
    clr(); collect(5);
    chk("half_pos", q_at(0), 16383);
    chk("half_neg", q_at(2), -16384);
    stop();

    // Triangle, small step: rising ramp.
    cfg(2'b10, 16'h0100, 8'd128, 16'd0);
    clr(); collect(6);
    chk("tri_r0", q_at(0), -32767);
    chk("tri_r1", q_at(1), -32255);
    chk("tri_r2", q_at(2), -31743);
    chk("tri_r3", q_at(3), -31231);
    stop();

    // Triangle at quarter points: rise midpoint, peak, fall midpoint.
    cfg(2'b10, 16'h4000, 8'd128, 16'd0);
    clr(); collect(6);
    chk("tri_q0", q_at(0), -32767);
    chk("tri_q1", q_at(1), 1);
    chk("tri_q2", q_at(2), 32767);
    chk("tri_q3", q_at(3), -1);
    stop();

    // Zero amplitude still writes zeros.
    cfg(2'b11, 16'h4000, 8'd0, 16'd0);
    clr(); collect(5);
    chk("amp0_count", wq.size(), 3);
    chk("amp0_s0", q_at(0), 0);
    chk("amp0_s2", q_at(2), 0);
    stop();

    // Sine from model ROM with a 5-cycle stall.
    cfg(2'b00, 16'h0300, 8'd128, 16'd0);
    clr(); collect(6);
    @(posedge clk); #1 fifo_full_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_wr_en", i), wr_en_o, 0);
      chk($sformatf("stall%0d_lut_en", i), lut_en_o, 0);
      chk($sformatf("stall%0d_data", i), data_o, rom_val(12));
    end
    @(posedge clk); #1 fifo_full_i = 1'b0;
    collect(8);
    chk("sine_count", wq.size(), 12);
    for (int i = 0; i < 12; i++) chk($sformatf("sine[%0d]", i), q_at(i), rom_val(3 * i));
    stop();

    // Burst of 4.
    cfg(2'b00, 16'h1000, 8'd128, 16'd4);
    clr(); collect(10);
    chk("burst_count", wq.size(), 4);
    chk("burst_done_cnt", done_cnt, 1);
    chk("burst_done_with_4th", done_idx, 4);
    chk("burst_s0", q_at(0), rom_val(0));
    chk("burst_s3", q_at(3), rom_val(48));
    chk("burst_busy_after", busy_o, 0);
    chk("burst_lut_en_after", lut_en_o, 0);

    // Reconfigure to cosine while running.
    cfg(2'b00, 16'h0300, 8'd128, 16'd0);
    clr(); collect(4);
    chk("pre_cos_s0", q_at(0), rom_val(0));
    @(posedge clk); #1 cfg_i = 1'b1; sel_i = 2'b01;
    @(posedge clk); #1 cfg_i = 1'b0;
    @(negedge clk);
    chk("config_wr_en", wr_en_o, 0);
    chk("config_busy", busy_o, 1);
    @(posedge clk); #1;
    clr(); collect(6);
    chk("cos_first_wr_cycle", first_idx, 2);
    chk("cos_count", wq.size(), 4);
    chk("cos_s0", q_at(0), rom_val(64));
    chk("cos_s1", q_at(1), rom_val(67));
    chk("cos_s2", q_at(2), rom_val(70));

    // Asynchronous reset in the middle of a running stream.
    @(posedge clk); #1;
    chk("pre_rst_wr_en", wr_en_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_wr_en", wr_en_o, 0);
    chk("midrst_data", data_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_lut_en", lut_en_o, 0);
    chk("midrst_done", done_o, 0);
    #10 rst = 1'b0;
    clr(); collect(4);
    chk("post_rst_writes", wq.size(), 0);
    chk("post_rst_busy", busy_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
